par_ser_cmd_tx: RTL and testbench

// - Parallel-to-serial transmitter for the SD CMD line; MSb first. Pairs with the serial-to-parallel

---
 rtl/sd_tx_pkg.sv | 20 ++
 rtl/par_ser_cmd_tx_if.sv | 22 ++
 rtl/crc7_serial.sv | 35 +++
 rtl/par_ser_cmd_tx.sv | 134 +++++++++++++
 tb/tb_par_ser_cmd_tx.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sd_tx_pkg.sv
// Shared types and CRC7 constants for the SD command/response serial paths.
package sd_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    localparam int unsigned CRC7_W = 7;
    localparam logic [CRC7_W-1:0] CRC7_POLY = 7'h09;

    // One serial step of the x^7+x^3+1 CRC, data bit entering at the MSb end.
    function automatic logic [CRC7_W-1:0] crc7_step(input logic [CRC7_W-1:0] crc,
                                                    input logic             bit_in);
        logic fb;
        fb = bit_in ^ crc[CRC7_W-1];
        return {crc[CRC7_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : CRC7_W'(0));
    endfunction

endpackage

// File: rtl/par_ser_cmd_tx_if.sv
// Frame handshake and CMD-line signals between the command-issue FSM and the serializer.
interface par_ser_cmd_tx_if #(
    parameter int unsigned NumBits = 48
);
    logic [NumBits-1:0] dat_par_i;
    logic               dat_valid_i;
    logic               dat_ready_o;
    logic               dat_ser_o;
    logic               dat_ser_oe_o;
    logic               busy_o;
    logic               done_o;

    modport master (
        output dat_par_i, dat_valid_i,
        input  dat_ready_o, dat_ser_o, dat_ser_oe_o, busy_o, done_o
    );

    modport slave (
        input  dat_par_i, dat_valid_i,
        output dat_ready_o, dat_ser_o, dat_ser_oe_o, busy_o, done_o
    );
endinterface

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 accumulator, shared by the CMD transmit and response check paths.
module crc7_serial
    import sd_tx_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              bit_i,
    output logic [CRC7_W-1:0] crc_o
);

    logic [CRC7_W-1:0] crc_q;
    logic [CRC7_W-1:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = crc7_step(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/par_ser_cmd_tx.sv
// SD CMD-line parallel-to-serial transmitter, MSb first, one bit per shift_en_i strobe.
// Optional CRC7 insertion on frame bits [7:1] when PAR_SER_CMD_TX_CRC7_EN is defined.
module par_ser_cmd_tx
    import sd_tx_pkg::*;
#(
    parameter int unsigned NumBits = 48
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                shift_en_i,
    par_ser_cmd_tx_if.slave     tx_if
);

    localparam int unsigned CntW = $clog2(NumBits + 1);

    tx_state_e          state_q, state_d;
    logic [NumBits-1:0] shift_q, shift_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               ser_q, ser_d;
    logic               oe_q, oe_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic load_c;
    logic step_c;
    logic last_c;
    logic next_bit_c;

    assign load_c = (state_q == IDLE) && tx_if.dat_valid_i;
    assign step_c = (state_q == SHIFT) && shift_en_i;
    assign last_c = step_c && (cnt_q == CntW'(NumBits - 1));

`ifdef PAR_SER_CMD_TX_CRC7_EN
    logic [CRC7_W-1:0] crc_c;
    logic              crc_bit_c;
    logic              crc_phase_c;
    logic              unused_crc_c;

    // Accumulate over the payload, then feed the CRC MSb back so the register shifts out.
    assign crc_bit_c   = (cnt_q < CntW'(NumBits - 8)) ? shift_q[NumBits-1] : crc_c[CRC7_W-1];
    assign crc_phase_c = (cnt_q >= CntW'(NumBits - 9)) && (cnt_q <= CntW'(NumBits - 3));
    // Poly bit 6 is zero, so the post-step CRC MSb is always the pre-step bit 5.
    assign next_bit_c   = crc_phase_c ? crc_c[CRC7_W-2] : shift_q[NumBits-2];
    assign unused_crc_c = ^crc_c[CRC7_W-3:0];

    crc7_serial u_crc7 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (load_c),
        .en_i   (step_c),
        .bit_i  (crc_bit_c),
        .crc_o  (crc_c)
    );
`else
    logic unused_msb_c;

    assign unused_msb_c = shift_q[NumBits-1];
    assign next_bit_c   = shift_q[NumBits-2];
`endif

    // Next state and next registered line/handshake outputs.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ser_d   = ser_q;
        oe_d    = oe_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load_c) begin
                    state_d = SHIFT;
                    shift_d = tx_if.dat_par_i;
                    cnt_d   = '0;
                    ser_d   = tx_if.dat_par_i[NumBits-1];
                    oe_d    = 1'b1;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (step_c) begin
                    shift_d = {shift_q[NumBits-2:0], 1'b1};
                    cnt_d   = cnt_q + CntW'(1);
                    ser_d   = next_bit_c;
                    if (last_c) begin
                        state_d = IDLE;
                        ser_d   = 1'b1;
                        oe_d    = 1'b0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b1;
            oe_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            oe_q    <= oe_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_if.dat_ser_o    = ser_q;
    assign tx_if.dat_ser_oe_o = oe_q;
    assign tx_if.dat_ready_o  = ready_q;
    assign tx_if.busy_o       = busy_q;
    assign tx_if.done_o       = done_q;

endmodule

// File: tb/tb_par_ser_cmd_tx.sv
// Self-checking bench for par_ser_cmd_tx: vector table, corner sequences and random traffic
// against a frame-level reference model (CRC expectations follow PAR_SER_CMD_TX_CRC7_EN).
module tb_par_ser_cmd_tx;

    localparam int unsigned N = 48;

    logic clk = 1'b0;
    logic rst_n;
    logic shift_en;

    par_ser_cmd_tx_if #(.NumBits(N)) tx_if ();

    par_ser_cmd_tx #(.NumBits(N)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .shift_en_i (shift_en),
        .tx_if      (tx_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame in flight, strobes consumed so far, expected line sequence.
    bit           m_active = 1'b0;
    bit           m_done   = 1'b0;
    int           m_k      = 0;
    int           m_loads  = 0;
    logic [N-1:0] m_seq    = '0;

    logic [N-1:0] cap;
    int           cap_n;
    int           dones;

    typedef struct {
        logic [N-1:0] par;
        int           period;
        bit           sen_at_load;
        logic [N-1:0] exp_line;
    } vec_t;

    vec_t vecs[4];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line sequence for a frame: verbatim, or with bits [7:1] replaced by its CRC7.
    function automatic logic [N-1:0] line_of(input logic [N-1:0] par);
        logic [N-1:0] seq;
        seq = par;
`ifdef PAR_SER_CMD_TX_CRC7_EN
        begin
            logic [N-2:0] d;
            d = {par[N-1:8], 7'b0};
            for (int i = N - 2; i >= 7; i--) begin
                if (d[i]) d[i -: 8] = d[i -: 8] ^ 8'h89;
            end
            seq[7:1] = d[6:0];
        end
`endif
        return seq;
    endfunction

    function automatic logic [4:0] outs();
        return {tx_if.dat_ser_o, tx_if.dat_ser_oe_o, tx_if.dat_ready_o, tx_if.busy_o, tx_if.done_o};
    endfunction

    function automatic logic [4:0] exp_outs();
        if (m_active) return {m_seq[N-1-m_k], 1'b1, 1'b0, 1'b1, 1'b0};
        return {1'b1, 1'b0, 1'b1, 1'b0, m_done};
    endfunction

    function automatic logic [N-1:0] rnd();
        return N'({$urandom(), $urandom()});
    endfunction

    // One cycle: check outputs against the model, apply inputs, advance the model.
    task automatic drive(input bit valid, input logic [N-1:0] par, input bit sen);
        cmp("outputs", 64'(outs()), 64'(exp_outs()));
        if (tx_if.done_o) dones++;
        if (sen && m_active) begin
            cap[N-1-m_k] = tx_if.dat_ser_o;
            cap_n++;
        end
        tx_if.dat_valid_i = valid;
        tx_if.dat_par_i   = par;
        shift_en          = sen;
        m_done = 1'b0;
        if (!m_active) begin
            if (valid) begin
                m_active = 1'b1;
                m_k      = 0;
                m_seq    = line_of(par);
                m_loads++;
            end
        end else if (sen) begin
            m_k++;
            if (m_k == N) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int ph;
        int guard;
        cap   = '0;
        cap_n = 0;
        dones = 0;
        ph    = 0;
        guard = 0;
        drive(1'b1, v.par, v.sen_at_load);
        while (m_active && guard < 2000) begin
            drive(1'b0, rnd(), (ph % v.period) == (v.period - 1));
            ph++;
            guard++;
        end
        if (guard >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: frame still active after %0d cycles", tag, guard);
        end
        repeat (3) drive(1'b0, rnd(), 1'b0);
        cmp({tag, "_line"}, 64'(cap), 64'(v.exp_line));
        cmp({tag, "_strobes"}, 64'(cap_n), 64'(N));
        cmp({tag, "_done_pulses"}, 64'(dones), 64'd1);
    endtask

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        bit           seen_done;
        int           cyc;

        vecs[0] = '{48'h40_0000_0000_95, 1, 1'b0, 48'h40_0000_0000_95};
`ifdef PAR_SER_CMD_TX_CRC7_EN
        vecs[1] = '{48'h40_0000_0000_00, 1, 1'b0, 48'h40_0000_0000_94};
        vecs[2] = '{48'h48_0000_01AA_01, 4, 1'b0, 48'h48_0000_01AA_87};
`else
        vecs[1] = '{48'h40_0000_0000_00, 1, 1'b0, 48'h40_0000_0000_00};
        vecs[2] = '{48'h48_0000_01AA_01, 4, 1'b0, 48'h48_0000_01AA_01};
`endif
        vecs[3] = '{48'h48_0000_01AA_87, 2, 1'b1, 48'h48_0000_01AA_87};

        rst_n             = 1'b0;
        shift_en          = 1'b0;
        tx_if.dat_valid_i = 1'b0;
        tx_if.dat_par_i   = '0;
        repeat (2) @(negedge clk);
        cmp("reset_state", 64'(outs()), 64'h14);
        rst_n = 1'b1;
        repeat (2) drive(1'b0, '0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back with valid held: second frame loads in the done cycle.
        a         = 48'h40_0000_0000_95;
        b         = 48'h48_0000_01AA_87;
        seen_done = 1'b0;
        cyc       = 0;
        cap       = '0;
        while (!(m_loads >= 6 && !m_active) && cyc < 2000) begin
            bit was_done;
            was_done = tx_if.done_o;
            drive(1'b1, (m_loads < 5) ? a : b, (cyc % 4) == 3);
            cyc++;
            if (was_done && !seen_done) begin
                seen_done = 1'b1;
                cmp("b2b_oe_after_done", 64'(tx_if.dat_ser_oe_o), 64'd1);
                cmp("b2b_first_bit", 64'(tx_if.dat_ser_o), 64'(b[N-1]));
            end
        end
        cmp("b2b_loads", 64'(m_loads), 64'd6);
        cmp("b2b_line", 64'(cap), 64'(b));
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);

        // Reset mid-frame after 10 strobes: immediate reset values, no done pulse.
        dones = 0;
        drive(1'b1, a, 1'b0);
        repeat (10) drive(1'b0, rnd(), 1'b1);
        drive(1'b0, rnd(), 1'b0);
        #2 rst_n = 1'b0;
        #1 cmp("rst_async_outputs", 64'(outs()), 64'h14);
        m_active = 1'b0;
        m_done   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) drive(1'b0, rnd(), 1'b1);
        cmp("rst_no_done", 64'(dones), 64'd0);
        run_vec(vecs[0], "after_rst");

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) == 0, rnd(), $urandom_range(0, 1) == 1);
        end
        cmp("rand_frames_loaded", 64'(m_loads > 20), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
